game_collision_detector: RTL and testbench
==========================================

GAME_COLLISION_DETECTOR -- requirements
Module: game_collision_detector

Interface
REQ-001 Parameter MIN_OVERLAP, default 4: opaque-overlap pixels per frame needed to declare a hit (range 1..2**CNT_W-1).
REQ-002 Parameter CNT_W, default 8: width of each per-frame overlap counter.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 frame_start  input  1  one-cycle pulse marking the first pixel cycle of each frame.
REQ-006 pixel_valid  input  1  current pixel lies in the active display area.
REQ-007 target_en_1, target_en_2, target_en_3  input  1 each  target sprite N is opaque at the current pixel.
REQ-008 torpedo_en  input  1  torpedo sprite is opaque at the current pixel.
REQ-009 bullet_en  input  1  bullet sprite is opaque at the current pixel.
REQ-010 collision  output  1  torpedo hit any target in the last completed frame; feeds the game master FSM.
REQ-011 collision_bullet  output  1  bullet hit any target in the last completed frame; feeds the game master FSM.
REQ-012 bullet_hit_target  output  3  one-hot-or-more: bit N-1 set when the bullet hit target N in the last completed frame.
REQ-013 frame_valid  output  1  high once at least one complete frame has been evaluated since reset.

Function
REQ-014 The block SHALL have two states: WAIT_FIRST (initial) and ACCUM.
REQ-015 WAIT_FIRST: on frame_start, clear all counters and go to ACCUM; outputs stay 0.
REQ-016 ACCUM: for each pixel with pixel_valid=1, increment each relevant counter by 1.
REQ-017 Counter T (torpedo): increments when torpedo_en & (target_en_1 | target_en_2 | target_en_3).
REQ-018 Counters B1..B3 (bullet vs target N): increment when bullet_en & target_en_N.
REQ-019 Counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-020 Pixels with pixel_valid=0 SHALL NOT change any counter.
REQ-021 ACCUM on frame_start publish, registered, on the following edge:
- collision = (T >= MIN_OVERLAP)
- bullet_hit_target[N-1] = (BN >= MIN_OVERLAP)
- collision_bullet = OR of bullet_hit_target
- frame_valid = 1
REQ-022 On the same frame_start, all counters SHALL restart.
REQ-023 A frame_start cycle that is itself a qualifying pixel SHALL count toward the new frame, so each counter loads 1, not 0.
REQ-024 Latency: an overlap in frame K appears on the outputs exactly 1 cycle after the frame_start that opens frame K+1.
REQ-025 Published outputs SHALL hold constant until the next frame_start and SHALL NOT glitch mid-frame.
REQ-026 Two frame_start pulses on consecutive cycles SHALL each publish normally; the second publishes all-zero hits unless the frame_start pixel alone reaches MIN_OVERLAP.
REQ-027 Simultaneous torpedo and bullet overlaps in the same frame SHALL assert collision and collision_bullet together; resolving priority is the game master's job.
REQ-028 A single pixel may increment T and several BN counters in the same cycle.

Reset
REQ-029 When rst=0 at a clock edge:
- state = WAIT_FIRST
- all counters = 0
- collision = 0, collision_bullet = 0, bullet_hit_target = 3'b000, frame_valid = 0
REQ-030 Reset mid-frame SHALL discard the partial frame; the next frame_start after release only starts accumulation and publishes nothing.
REQ-031 Reset SHALL take priority over frame_start in the same cycle.

Structure
REQ-032 The shared game configuration package SHALL hold the state enum type, the MIN_OVERLAP default, the CNT_W default, and the number of targets (3).
REQ-033 A sub-module game_overlap_counter SHALL hold the saturating counter, its restart-on-frame_start loading and the threshold compare; it is instantiated 4 times (T, B1..B3).
REQ-034 The top module SHALL contain only the state register, the increment-condition logic and the output registers.

Verification
REQ-035 Reset, then 3 frames with no overlap -> all outputs 0; frame_valid rises 1 cycle after the 2nd frame_start and stays 1.
REQ-036 Torpedo over target_2 for exactly 4 valid pixels in one frame -> collision=1 for exactly the next frame; 3 pixels -> collision stays 0.
REQ-037 Bullet over targets 1 and 3 for 10 pixels each in one frame -> bullet_hit_target=3'b101 and collision_bullet=1 for one frame, then 0.
REQ-038 CNT_W=3, 20 overlapping pixels -> counter holds at 7 with no wrap, and the hit is reported.
REQ-039 Overlap on 4 pixels with pixel_valid=0 -> no hit. Overlap on the frame_start cycle plus 3 more pixels -> hit reported one frame later.
REQ-040 Assert rst=0 mid-frame after 10 overlapping pixels -> outputs 0 immediately; after release, the first frame_start publishes nothing and the second publishes only that frame's overlaps.

Source files
------------

// File: rtl/game_collision_detector_pkg.sv
// Shared game configuration: detector state type, default thresholds and target count.
package game_collision_detector_pkg;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    ACCUM      = 1'b1
  } state_t;

  localparam int unsigned DEF_MIN_OVERLAP = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned NUM_TARGETS     = 3;

endpackage

// File: rtl/game_overlap_counter.sv
// Saturating per-frame overlap counter with frame restart and hit-threshold compare.
module game_overlap_counter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_OVERLAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_inc,
  output logic o_hit
);

  localparam logic [CNT_W-1:0] C_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(MIN_OVERLAP);

  logic [CNT_W-1:0] r_count;

  // Restart loads the current pixel so a qualifying frame_start pixel counts as 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_restart) begin
      r_count <= CNT_W'(i_inc);
    end else if (i_inc && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_hit = (r_count >= C_THRESH);

endmodule

// File: rtl/game_collision_detector.sv
// Per-frame sprite collision detector: accumulates torpedo/bullet overlaps and
// publishes registered hit flags one cycle after each frame_start.
module game_collision_detector
  import game_collision_detector_pkg::*;
#(
  parameter int unsigned MIN_OVERLAP = DEF_MIN_OVERLAP,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic                   target_en_1,
  input  logic                   target_en_2,
  input  logic                   target_en_3,
  input  logic                   torpedo_en,
  input  logic                   bullet_en,
  output logic                   collision,
  output logic                   collision_bullet,
  output logic [NUM_TARGETS-1:0] bullet_hit_target,
  output logic                   frame_valid
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_restart;
  logic                   w_publish;
  logic                   w_count_en;
  logic [NUM_TARGETS-1:0] w_targets;
  logic [NUM_TARGETS:0]   w_inc;
  logic [NUM_TARGETS:0]   w_hit;

  assign w_targets = {target_en_3, target_en_2, target_en_1};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= WAIT_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, restart/publish strobes and counting window.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_publish   = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        if (frame_start) begin
          w_state_nxt = ACCUM;
          w_restart   = 1'b1;
          w_count_en  = 1'b1;
        end else begin
          w_state_nxt = WAIT_FIRST;
        end
      end
      ACCUM: begin
        w_count_en = 1'b1;
        if (frame_start) begin
          w_restart = 1'b1;
          w_publish = 1'b1;
        end else begin
          w_restart = 1'b0;
        end
      end
      default: begin
        w_state_nxt = WAIT_FIRST;
      end
    endcase
  end

  // Index 0 is the torpedo counter, index N is bullet versus target N.
  always_comb begin
    w_inc    = {(NUM_TARGETS+1){1'b0}};
    w_inc[0] = w_count_en & pixel_valid & torpedo_en & (|w_targets);
    for (int i = 1; i <= NUM_TARGETS; i++) begin
      w_inc[i] = w_count_en & pixel_valid & bullet_en & w_targets[i-1];
    end
  end

  for (genvar g = 0; g <= NUM_TARGETS; g++) begin : g_cnt
    game_overlap_counter #(
      .CNT_W      (CNT_W),
      .MIN_OVERLAP(MIN_OVERLAP)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_restart(w_restart),
      .i_inc    (w_inc[g]),
      .o_hit    (w_hit[g])
    );
  end

  // Published results; counter hits are sampled before the frame_start pixel lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      collision         <= 1'b0;
      collision_bullet  <= 1'b0;
      bullet_hit_target <= {NUM_TARGETS{1'b0}};
      frame_valid       <= 1'b0;
    end else if (w_publish) begin
      collision         <= w_hit[0];
      collision_bullet  <= |w_hit[NUM_TARGETS:1];
      bullet_hit_target <= w_hit[NUM_TARGETS:1];
      frame_valid       <= 1'b1;
    end else begin
      collision         <= collision;
      collision_bullet  <= collision_bullet;
      bullet_hit_target <= bullet_hit_target;
      frame_valid       <= frame_valid;
    end
  end

endmodule

// File: tb/tb_game_collision_detector.sv
// Directed bench: default detector plus a narrow-counter (CNT_W=3, MIN_OVERLAP=7) copy.
module tb_game_collision_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [2:0] tg = 3'b000;
  logic       torpedo_en = 1'b0;
  logic       bullet_en = 1'b0;

  logic       col0, cb0, fv0, col1, cb1, fv1;
  logic [2:0] bht0, bht1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  game_collision_detector dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .target_en_1(tg[0]), .target_en_2(tg[1]), .target_en_3(tg[2]),
    .torpedo_en(torpedo_en), .bullet_en(bullet_en),
    .collision(col0), .collision_bullet(cb0), .bullet_hit_target(bht0), .frame_valid(fv0)
  );

  game_collision_detector #(.MIN_OVERLAP(7), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .target_en_1(tg[0]), .target_en_2(tg[1]), .target_en_3(tg[2]),
    .torpedo_en(torpedo_en), .bullet_en(bullet_en),
    .collision(col1), .collision_bullet(cb1), .bullet_hit_target(bht1), .frame_valid(fv1)
  );

  // One pixel cycle; returns 1 time unit after the capturing edge.
  task automatic px(input logic fs, input logic pv, input logic [2:0] t,
                    input logic tp, input logic b);
    frame_start = fs;
    pixel_valid = pv;
    tg          = t;
    torpedo_en  = tp;
    bullet_en   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input int n, input logic pv, input logic [2:0] t,
                     input logic tp, input logic b);
    for (int i = 0; i < n; i++) px(1'b0, pv, t, tp, b);
  endtask

  // Compared vector: {frame_valid, collision, collision_bullet, bullet_hit_target}.
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  function automatic logic [5:0] o0();
    return {fv0, col0, cb0, bht0};
  endfunction

  function automatic logic [5:0] o1();
    return {fv1, col1, cb1, bht1};
  endfunction

  initial begin
    rst = 1'b0;
    px(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    chk("reset_state", o0(), 6'b000000);
    rst = 1'b1;

    // Three overlap-free frames.
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("first_fs_no_publish", o0(), 6'b000000);
    rep(5, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("second_fs_valid", o0(), 6'b100000);
    rep(5, 1'b1, 3'b001, 1'b0, 1'b0);
    chk("valid_holds", o0(), 6'b100000);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("third_fs_clean", o0(), 6'b100000);

    // Torpedo over target 2: 4 pixels hit, 3 do not.
    rep(4, 1'b1, 3'b010, 1'b1, 1'b0);
    rep(2, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("torp4_hit", o0(), 6'b110000);
    rep(3, 1'b1, 3'b010, 1'b1, 1'b0);
    chk("torp_hold_midframe", o0(), 6'b110000);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("torp3_miss", o0(), 6'b100000);

    // Bullet over targets 1 and 3.
    rep(10, 1'b1, 3'b101, 1'b0, 1'b1);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("bullet_t1_t3", o0(), 6'b101101);
    rep(4, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("bullet_clears", o0(), 6'b100000);

    // Torpedo and bullet on target 1 together for 20 pixels; narrow copy must saturate.
    rep(20, 1'b1, 3'b001, 1'b1, 1'b1);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("simul_hit", o0(), 6'b111001);
    chk("sat_cnt3_hit", o1(), 6'b111001);
    rep(6, 1'b1, 3'b100, 1'b1, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("torp6_default", o0(), 6'b110000);
    chk("torp6_cnt3_miss", o1(), 6'b100000);

    // Invalid pixels never count; a qualifying frame_start pixel counts for the new frame.
    rep(4, 1'b0, 3'b010, 1'b1, 1'b0);
    px(1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
    chk("pv0_no_hit", o0(), 6'b100000);
    rep(3, 1'b1, 3'b010, 1'b1, 1'b0);
    rep(2, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("fs_pixel_counts", o0(), 6'b110000);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("back_to_back_fs", o0(), 6'b100000);

    // Reset mid-frame, with frame_start in the same cycle.
    rep(5, 1'b1, 3'b100, 1'b1, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("pre_reset_hit", o0(), 6'b110000);
    rep(10, 1'b1, 3'b100, 1'b1, 1'b0);
    rst = 1'b0;
    px(1'b1, 1'b1, 3'b100, 1'b1, 1'b0);
    chk("midframe_reset", o0(), 6'b000000);
    rst = 1'b1;
    rep(2, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("post_reset_fs1", o0(), 6'b000000);
    rep(2, 1'b1, 3'b100, 1'b1, 1'b0);
    rep(2, 1'b1, 3'b000, 1'b0, 1'b0);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("post_reset_fs2", o0(), 6'b100000);
    rep(4, 1'b1, 3'b010, 1'b0, 1'b1);
    px(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("bullet_t2", o0(), 6'b101010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
